// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port system RAM between CPU and DMA, CPU first with a bounded DMA wait
module ram_arbiter #(
    parameter int MAX_STARVE = 4,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [14:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic        dma_rvalid,
    output logic [7:0]  dma_rdata,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata
);
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             rvalid_q, rvalid_d;
    logic             at_max, force_dma, cpu_win, dma_win;
    always_comb begin
        at_max    = starve_q == CNT_W'(MAX_STARVE);
        force_dma = dma_req & at_max;
        cpu_win   = cpu_req & ~force_dma & ~reset;
        dma_win   = dma_req & ~cpu_win & ~reset;
        cpu_stall = cpu_req & ~cpu_win & ~reset;
        dma_ack   = dma_win;
        ram_addr  = dma_win ? dma_addr : cpu_addr;
        ram_wdata = dma_win ? dma_wdata : cpu_wdata;
        ram_we    = dma_win ? dma_we : cpu_we & cpu_win;
        rvalid_d  = dma_win & ~dma_we;
        starve_d  = (~dma_req | dma_win) ? '0 : at_max ? starve_q : starve_q + CNT_W'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
        end
    end
    // a reset arriving in the return cycle drops the pending read pulse
    assign dma_rvalid = rvalid_q & ~reset;
    assign dma_rdata  = ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with MAX_STARVE=4 and MAX_STARVE=0 instances
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset, cpu_req, cpu_we, dma_req, dma_we;
    logic [14:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        stall [2], ack [2], rvalid [2], rwe [2];
    logic [7:0]  rdata [2], rwd [2], ram_rd [2];
    logic [14:0] raddr [2];
    logic [7:0]  mem [2][0:32767];
    int          n_chk = 0, n_pass = 0;
    bit          chk_en = 1'b0;
    int          mx [2] = '{4, 0};
    int          waited [2] = '{0, 0};
    bit          rv_pend [2] = '{1'b0, 1'b0};
    logic [7:0]  rv_data [2];
    logic [7:0]  exp_mem [2][0:32767];

    always #5 clk = ~clk;

    ram_arbiter #(.MAX_STARVE(4), .CNT_W(8)) u4 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(stall[0]), .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(ack[0]), .dma_rvalid(rvalid[0]),
        .dma_rdata(rdata[0]), .ram_addr(raddr[0]), .ram_wdata(rwd[0]), .ram_we(rwe[0]),
        .ram_rdata(ram_rd[0]));

    ram_arbiter #(.MAX_STARVE(0), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(stall[1]), .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(ack[1]), .dma_rvalid(rvalid[1]),
        .dma_rdata(rdata[1]), .ram_addr(raddr[1]), .ram_wdata(rwd[1]), .ram_we(rwe[1]),
        .ram_rdata(ram_rd[1]));

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32768; a++) begin
                mem[k][a] = 8'h00;
                exp_mem[k][a] = 8'h00;
            end
    end

    // synchronous-read RAM behind each arbiter
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ram_rd[k] <= mem[k][raddr[k]];
            if (rwe[k]) mem[k][raddr[k]] <= rwd[k];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    // model: DMA wins when the CPU is idle or it has already been refused MAX_STARVE times in a row
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit dw, cw, we;
                logic [14:0] a;
                logic [7:0] wd;
                dw = dma_req && !reset && (!cpu_req || waited[k] >= mx[k]);
                cw = cpu_req && !reset && !dw;
                a  = dw ? dma_addr : cpu_addr;
                wd = dw ? dma_wdata : cpu_wdata;
                we = dw ? dma_we : (cw && cpu_we);
                check($sformatf("u%0d ack", k), 32'(ack[k]), 32'(dw));
                check($sformatf("u%0d stall", k), 32'(stall[k]), 32'(cpu_req && !reset && !cw));
                check($sformatf("u%0d ram_we", k), 32'(rwe[k]), 32'(we));
                check($sformatf("u%0d ram_addr", k), 32'(raddr[k]), 32'(a));
                if (we) check($sformatf("u%0d ram_wdata", k), 32'(rwd[k]), 32'(wd));
                check($sformatf("u%0d rvalid", k), 32'(rvalid[k]), 32'(rv_pend[k] && !reset));
                if (rv_pend[k] && !reset) check($sformatf("u%0d rdata", k), 32'(rdata[k]), 32'(rv_data[k]));
                rv_pend[k] = dw && !dma_we;
                rv_data[k] = exp_mem[k][dma_addr];
                if (we) exp_mem[k][a] = wd;
                waited[k] = (reset || !dma_req || dw) ? 0 : waited[k] + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
        cyc();
    endtask

    initial begin
        logic [14:0] m15, s15;
        logic [4:0]  m5;
        int          c_ack1, c_stall1, c_we1, c_stall0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        // DMA write then read-back
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h1234; dma_wdata = 8'hA5;
        @(negedge clk);
        check("t1 ack", 32'(ack[0]), 32'd1);
        check("t1 we", 32'(rwe[0]), 32'd1);
        check("t1 addr", 32'(raddr[0]), 32'h1234);
        cyc();
        dma_we = 1'b0;
        cyc();
        dma_req = 1'b0;
        @(negedge clk);
        check("t1 rvalid", 32'(rvalid[0]), 32'd1);
        check("t1 rdata", 32'(rdata[0]), 32'hA5);
        cyc();
        // CPU alone, mixed reads and writes
        c_stall0 = 0;
        for (int i = 0; i < 20; i++) begin
            cpu_req = 1'b1; cpu_we = (i % 2) == 1;
            cpu_addr = 15'(i * 97 + 16); cpu_wdata = 8'(i * 3 + 1);
            @(negedge clk);
            if (stall[0]) c_stall0++;
            cyc();
        end
        check("t2 stalls", 32'(c_stall0), 32'd0);
        idle();
        // both requesting continuously
        m15 = '0; s15 = '0; c_ack1 = 0; c_stall1 = 0; c_we1 = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0100; cpu_wdata = 8'h5A;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h1234;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            m15[i] = ack[0]; s15[i] = stall[0];
            if (ack[1]) c_ack1++;
            if (stall[1]) c_stall1++;
            if (rwe[1]) c_we1++;
            cyc();
        end
        check("t3 ack pattern", 32'(m15), 32'h4210);
        check("t3 stall pattern", 32'(s15), 32'h4210);
        check("t4 acks", 32'(c_ack1), 32'd15);
        check("t4 stalls", 32'(c_stall1), 32'd15);
        check("t4 cpu writes", 32'(c_we1), 32'd0);
        idle();
        // reset mid-wait
        cpu_req = 1'b1; cpu_we = 1'b1; dma_req = 1'b1;
        repeat (3) cyc();
        reset = 1'b1;
        @(negedge clk);
        check("t5 ack in reset", 32'(ack[0]), 32'd0);
        check("t5 we in reset", 32'(rwe[0]), 32'd0);
        check("t5 stall in reset", 32'(stall[0]), 32'd0);
        cyc();
        reset = 1'b0;
        m5 = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m5[i] = ack[0];
            cyc();
        end
        check("t5 ack pattern", 32'(m5), 32'h10);
        idle();
        // DMA drops its request while waiting
        cpu_req = 1'b1; dma_req = 1'b1;
        repeat (2) cyc();
        dma_req = 1'b0;
        cyc();
        dma_req = 1'b1;
        m5 = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            m5[i] = ack[0];
            cyc();
        end
        check("t6 ack pattern", 32'(m5), 32'h10);
        idle();
        // reset in the return cycle of a DMA read
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h1234;
        cyc();
        dma_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("t7 rvalid in reset", 32'(rvalid[0]), 32'd0);
        cyc();
        reset = 1'b0;
        idle();
        idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
